// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types: register index / data widths,
// well-known register numbers, and the index and word typedefs.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0]     word_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_RA   = 5'd31;

endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port: the $0 check, the storage select,
// and (build macro RF_BYPASS_EN) write-through forwarding from the write port.
module rf_read_port
    import mips_pkg::*;
#(
    parameter int DATA_W   = mips_pkg::DATA_W,
    parameter int ADDR_W   = mips_pkg::REG_ADDR_W,
    parameter int NUM_REGS = 1 << ADDR_W
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] mem [NUM_REGS],
    input  logic              byp_en,
    input  logic [ADDR_W-1:0] byp_addr,
    input  logic [DATA_W-1:0] byp_data,
    output logic [DATA_W-1:0] data
);

`ifdef RF_BYPASS_EN
    logic hit;
    assign hit = byp_en && (byp_addr == addr);
`else
    // Without forwarding, the write-port signals are intentionally left unused.
    logic unused_bypass;
    assign unused_bypass = ^{byp_en, byp_addr, byp_data};
`endif

    // NOTE: default assignment first so every path drives data and no latch is inferred.
    always_comb begin
        data = '0;
        if (addr != ADDR_W'(REG_ZERO)) begin
`ifdef RF_BYPASS_EN
            if (hit) data = byp_data;
            else     data = mem[addr];
`else
            data = mem[addr];
`endif
        end
    end

endmodule

// File: rtl/mips_reg_file.sv
// MIPS 32 x 32 register file: two combinational read ports, one synchronous
// write port, $0 hardwired to zero. Optional forwarding: define RF_BYPASS_EN.
module mips_reg_file
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              reg_write,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data
);

    localparam int NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [NUM_REGS];
    logic              wr_en;

    // Gating with rst also keeps the forwarding path quiet during reset.
    assign wr_en = reg_write && !rst && (rd_addr != ADDR_W'(REG_ZERO));

    // NOTE: every entry is cleared by the async reset, so this array is flops, not a RAM macro;
    // <= keeps the update ordered against the combinational readers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[rd_addr] <= wr_data;
        end
    end

    rf_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_port_a (
        .addr     (rs_addr),
        .mem      (mem),
        .byp_en   (wr_en),
        .byp_addr (rd_addr),
        .byp_data (wr_data),
        .data     (rs_data)
    );

    rf_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_port_b (
        .addr     (rt_addr),
        .mem      (mem),
        .byp_en   (wr_en),
        .byp_addr (rd_addr),
        .byp_data (wr_data),
        .data     (rt_data)
    );

endmodule

// File: tb/tb_mips_reg_file.sv
// Scoreboard bench for mips_reg_file: stimulus queues expected read data per
// cycle, a negedge monitor pops and compares against rs_data / rt_data.
module tb_mips_reg_file;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;
    logic [4:0]  rd_addr = '0;
    logic [31:0] wr_data = '0;
    logic        reg_write = 1'b0;
    logic [31:0] rs_data;
    logic [31:0] rt_data;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
    } sb_item_t;

    sb_item_t sb[$];
    sb_item_t mon_item;
    int       checks   = 0;
    int       failures = 0;

    mips_reg_file dut (
        .clk       (clk),
        .rst       (rst),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rd_addr   (rd_addr),
        .wr_data   (wr_data),
        .reg_write (reg_write),
        .rs_data   (rs_data),
        .rt_data   (rt_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle of stimulus, driven just after the rising edge; the expected
    // combinational read data for this cycle is queued for the monitor.
    task automatic cyc(input logic r, input logic we, input logic [4:0] rd,
                       input logic [31:0] wd, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] exp_rs, input logic [31:0] exp_rt,
                       input string name);
        sb_item_t it;
        @(posedge clk);
        #1;
        rst       = r;
        reg_write = we;
        rd_addr   = rd;
        wr_data   = wd;
        rs_addr   = rs;
        rt_addr   = rt;
        it.name   = name;
        it.exp_rs = exp_rs;
        it.exp_rt = exp_rt;
        sb.push_back(it);
    endtask

    function automatic logic [31:0] sweep_val(input int idx);
        return (idx == 0) ? 32'h0 : ({27'b0, 5'(idx)} ^ 32'hA5A5A5A5);
    endfunction

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                mon_item = sb.pop_front();
                check({mon_item.name, ".rs"}, rs_data, mon_item.exp_rs);
                check({mon_item.name, ".rt"}, rt_data, mon_item.exp_rt);
            end
        end
    end

    initial begin : stimulus
        // Reset held from time 0: every address reads zero.
        for (int i = 0; i < 32; i++)
            cyc(1, 0, 0, 0, 5'(i), 5'(31 - i), 0, 0, $sformatf("rst0_%0d", i));
        cyc(0, 0, 0, 0, 5, 9, 0, 0, "rel");

        // Basic write/read of r5.
        cyc(0, 1, 5, 32'hDEADBEEF, 5, 5, BYP ? 32'hDEADBEEF : 32'h0,
            BYP ? 32'hDEADBEEF : 32'h0, "wr5_pre");
        cyc(0, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, "wr5_post");

        // $0 protection, including no forwarding of a write to $0.
        cyc(0, 1, 0, 32'hFFFFFFFF, 0, 5, 32'h0, 32'hDEADBEEF, "r0_pre");
        cyc(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, "r0_post");

        // Write disable.
        cyc(0, 0, 7, 32'h12345678, 7, 7, 32'h0, 32'h0, "wdis_pre");
        cyc(0, 0, 0, 0, 7, 7, 32'h0, 32'h0, "wdis_post");

        // Same-cycle read/write of r9 on each port.
        cyc(0, 1, 9, 32'h1, 0, 0, 32'h0, 32'h0, "raw_init");
        cyc(0, 1, 9, 32'h2, 9, 5, BYP ? 32'h2 : 32'h1, 32'hDEADBEEF, "raw_rs_pre");
        cyc(0, 0, 0, 0, 9, 9, 32'h2, 32'h2, "raw_rs_post");
        cyc(0, 1, 9, 32'h3, 5, 9, 32'hDEADBEEF, BYP ? 32'h3 : 32'h2, "raw_rt_pre");
        cyc(0, 0, 0, 0, 9, 9, 32'h3, 32'h3, "raw_rt_post");

        // Full sweep: fill r1..r31, then read every (rs, rt) pair.
        for (int i = 1; i < 32; i++)
            cyc(0, 1, 5'(i), sweep_val(i), 0, 0, 0, 0, $sformatf("fill_%0d", i));
        for (int a = 0; a < 32; a++)
            for (int b = 0; b < 32; b++)
                cyc(0, 0, 0, 0, 5'(a), 5'(b), sweep_val(a), sweep_val(b),
                    $sformatf("sweep_%0d_%0d", a, b));

        // Asynchronous reset mid-cycle with a write attempted during reset.
        cyc(1, 1, 3, 32'hCAFEF00D, 3, 31, 0, 0, "rst_wr");
        for (int i = 0; i < 32; i++)
            cyc(1, 1, 3, 32'hCAFEF00D, 5'(i), 5'(31 - i), 0, 0, $sformatf("rst1_%0d", i));
        cyc(0, 0, 0, 0, 3, 31, 0, 0, "rst_rel");

        // First write after deassertion lands on the next edge.
        cyc(0, 1, 3, 32'h0BADF00D, 3, 4, BYP ? 32'h0BADF00D : 32'h0, 32'h0, "post_rst_pre");
        cyc(0, 0, 0, 0, 3, 3, 32'h0BADF00D, 32'h0BADF00D, "post_rst_post");

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
